reorder_buffer_n: RTL and testbench
===================================

# reorder_buffer_n

Parametrised reorder buffer for the out-of-order core. It allocates entries in program order from rename/dispatch and accepts results out of order from NUM_WB functional-unit writeback channels (ALU, LSU, MUL by default). It retires completed entries in order to the regfile through a valid/ready commit port, and supports a full flush. It replaces the fixed three-port ROB: depth, data width and writeback channel count are generalised, and it adds commit backpressure, per-channel index routing and flush.

## Interface
- DEPTH, 16, number of entries; power of two, ≥2
- IDX_W, $clog2(DEPTH), ROB index width
- NUM_WB, 3, writeback channels; channel k occupies slice k of each packed bus
- DATA_W, 32, result width
- PREG_W, 5, physical destination register address width
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-low reset (sampled on rising edge of clk_i)
- alloc_valid_i  in  1  dispatch requests an entry
- alloc_ready_o  out  1  entry available (= ~full_o)
- alloc_prd_i  in  PREG_W  destination physical register
- alloc_pc_i  in  32  instruction PC
- alloc_idx_o  out  IDX_W  index granted to the current request (= tail)
- wb_valid_i  in  NUM_WB  per-channel writeback strobe
- wb_idx_i  in  NUM_WB*IDX_W  per-channel target index
- wb_value_i  in  NUM_WB*DATA_W  per-channel result
- commit_valid_o  out  1  head entry complete
- commit_ready_i  in  1  regfile accepts the commit
- commit_idx_o  out  IDX_W  head index
- commit_prd_o  out  PREG_W  head destination register
- commit_value_o  out  DATA_W  head result
- commit_pc_o  out  32  head PC
- flush_i  in  1  discard all entries
- empty_o  out  1  count_o == 0
- full_o  out  1  count_o == DEPTH
- count_o  out  IDX_W+1  occupied entries

## Operation
- Storage: per entry valid, done, prd, pc, value. Head and tail pointers are IDX_W bits and wrap modulo DEPTH. A separate IDX_W+1 count register disambiguates full from empty.
- Allocate fires on alloc_valid_i & alloc_ready_o. It writes prd/pc, sets valid=1 and done=0 at tail, and increments tail.
- A full ROB never accepts, even if a commit fires in the same cycle.
- Writeback on channel k where wb_valid_i[k]=1:
  - If entry wb_idx_i[k] is valid and not done, it stores value and sets done.
  - A write to an invalid or already-done entry is ignored.
  - Several channels targeting the same index in one cycle: the lowest-numbered channel wins.
  - A writeback to the index being allocated in the same cycle is ignored, because that entry is not yet valid.
- Commit: commit_valid_o = valid[head] & done[head], combinational from registered state.
  - Fires on commit_valid_o & commit_ready_i. It clears valid/done at head and increments head.
  - commit_idx_o/prd/value/pc are driven 0 while commit_valid_o=0.
- Count next = count + alloc_fire − commit_fire. Simultaneous allocate and commit leave count unchanged.
- Flush (flush_i=1) takes priority over everything:
  - Clears all valid/done bits.
  - Sets head=tail=count=0.
  - Allocate, writeback and commit in that cycle have no effect; commit_ready_i is ignored and the head is not retired.
- Reset (reset_i=0) has the same effect as flush and also zeroes all stored fields. It takes priority over flush_i and aborts any in-progress state.

## Timing
- Reset values: alloc_ready_o=1, alloc_idx_o=0, commit_valid_o=0, commit_idx/prd/value/pc=0, empty_o=1, full_o=0, count_o=0.
- Allocate in cycle N: the entry is valid from N+1. The earliest writeback is in N+1, and the earliest commit_valid_o is in N+2.
- Writeback in cycle M to the head: commit_valid_o=1 in M+1. Writeback bypass into the same-cycle commit is not provided.
- commit_valid_o remains high and its outputs remain stable while commit_ready_i=0.
- full_o, empty_o, count_o and alloc_ready_o are derived from registers only, with no combinational path from the *_i ports.
- Index wrap: after index DEPTH−1, tail and head return to 0.

## Test plan
- Reset, then allocate 3 entries (prd 5,6,7).
  - Required: alloc_idx_o 0,1,2 and count_o=3.
  - Then write back idx 2, 0, 1 out of order: commits appear in order idx0 → idx1 → idx2, one per cycle with commit_ready_i=1.
- Fill all 16 entries.
  - Required: full_o=1, alloc_ready_o=0; a 17th alloc_valid_i is not accepted and count_o stays 16.
  - Then commit one entry: alloc_ready_o=1 next cycle and the new entry gets alloc_idx_o=0 (wrap).
- All three channels write back idx 4 with values 0xA, 0xB, 0xC in the same cycle.
  - Required: committed value = 0xA.
  - A second writeback to idx 4 afterwards is ignored.
- Head done and commit_ready_i held 0 for 5 cycles.
  - Required: commit_valid_o stays 1 with stable outputs.
  - Raising ready in the same cycle as an allocation leaves count unchanged.
- Flush with 6 entries, 3 done, while an allocate and a writeback are also asserted.
  - Required next cycle: count_o=0, empty_o=1, commit_valid_o=0, alloc_idx_o=0.
  - A writeback to old idx 2 afterwards is ignored.
- Assert reset_i=0 mid-stream with 10 entries.
  - Required: all outputs at their reset values the next cycle, identical to flush.

Source files
------------

// File: rtl/reorder_buffer_n.sv
// Reorder buffer: in-order allocate, out-of-order writeback on NUM_WB channels,
// in-order commit with valid/ready backpressure, and a single-cycle full flush.
module reorder_buffer_n #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned IDX_W  = $clog2(DEPTH),
   parameter int unsigned NUM_WB = 3,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PREG_W = 5
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     alloc_valid_i,
   output logic                     alloc_ready_o,
   input  logic [PREG_W-1:0]        alloc_prd_i,
   input  logic [31:0]              alloc_pc_i,
   output logic [IDX_W-1:0]         alloc_idx_o,
   input  logic [NUM_WB-1:0]        wb_valid_i,
   input  logic [NUM_WB*IDX_W-1:0]  wb_idx_i,
   input  logic [NUM_WB*DATA_W-1:0] wb_value_i,
   output logic                     commit_valid_o,
   input  logic                     commit_ready_i,
   output logic [IDX_W-1:0]         commit_idx_o,
   output logic [PREG_W-1:0]        commit_prd_o,
   output logic [DATA_W-1:0]        commit_value_o,
   output logic [31:0]              commit_pc_o,
   input  logic                     flush_i,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [IDX_W:0]           count_o
);

   localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  done_q, done_d;
   logic [PREG_W-1:0] prd_q   [DEPTH];
   logic [PREG_W-1:0] prd_d   [DEPTH];
   logic [31:0]       pc_q    [DEPTH];
   logic [31:0]       pc_d    [DEPTH];
   logic [DATA_W-1:0] value_q [DEPTH];
   logic [DATA_W-1:0] value_d [DEPTH];
   logic [IDX_W-1:0]  head_q, head_d;
   logic [IDX_W-1:0]  tail_q, tail_d;
   logic [IDX_W:0]    count_q, count_d;

   logic              full;
   logic              alloc_fire;
   logic              commit_valid;
   logic              commit_fire;
   logic [DEPTH-1:0]  wb_hit;
   logic [DATA_W-1:0] wb_data [DEPTH];

   assign full         = (count_q == FULL_CNT);
   // A full ROB refuses allocation even if the head retires this cycle.
   assign alloc_fire   = alloc_valid_i & ~full;
   assign commit_valid = valid_q[head_q] & done_q[head_q];
   assign commit_fire  = commit_valid & commit_ready_i;

   // Route writeback channels to entries; scanning high to low lets the lowest channel win.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         wb_hit[i]  = 1'b0;
         wb_data[i] = '0;
         for (int k = int'(NUM_WB) - 1; k >= 0; k--) begin
            if (wb_valid_i[k] && (wb_idx_i[k*IDX_W +: IDX_W] == IDX_W'(i))) begin
               wb_hit[i]  = 1'b1;
               wb_data[i] = wb_value_i[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Next-state: writeback, commit, allocate, count; flush overrides all of them.
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      prd_d   = prd_q;
      pc_d    = pc_q;
      value_d = value_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);

      // The entry being allocated is still invalid here, so same-cycle writebacks to it drop.
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (wb_hit[i] && valid_q[i] && !done_q[i]) begin
            done_d[i]  = 1'b1;
            value_d[i] = wb_data[i];
         end
      end

      if (commit_fire) begin
         valid_d[head_q] = 1'b0;
         done_d[head_q]  = 1'b0;
         head_d          = head_q + IDX_ONE;
      end

      if (alloc_fire) begin
         valid_d[tail_q] = 1'b1;
         done_d[tail_q]  = 1'b0;
         prd_d[tail_q]   = alloc_prd_i;
         pc_d[tail_q]    = alloc_pc_i;
         tail_d          = tail_q + IDX_ONE;
      end

      if (flush_i) begin
         valid_d = '0;
         done_d  = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // State register with synchronous active-low reset that also clears stored fields.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            prd_q[i]   <= '0;
            pc_q[i]    <= '0;
            value_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            prd_q[i]   <= prd_d[i];
            pc_q[i]    <= pc_d[i];
            value_q[i] <= value_d[i];
         end
      end
   end

   // Outputs come from registered state only; commit fields are zeroed when not valid.
   always_comb begin
      alloc_ready_o  = ~full;
      alloc_idx_o    = tail_q;
      full_o         = full;
      empty_o        = (count_q == '0);
      count_o        = count_q;
      commit_valid_o = commit_valid;
      commit_idx_o   = '0;
      commit_prd_o   = '0;
      commit_value_o = '0;
      commit_pc_o    = '0;
      if (commit_valid) begin
         commit_idx_o   = head_q;
         commit_prd_o   = prd_q[head_q];
         commit_value_o = value_q[head_q];
         commit_pc_o    = pc_q[head_q];
      end
   end

endmodule

// File: tb/tb_reorder_buffer_n.sv
// Bench for reorder_buffer_n: queue-based program-order model checked every cycle,
// plus directed literal checks on the key scenarios and a randomized run.
module tb_reorder_buffer_n;

   localparam int DEPTH  = 16;
   localparam int IDX_W  = 4;
   localparam int NUM_WB = 3;
   localparam int DATA_W = 32;
   localparam int PREG_W = 5;

   logic                     clk = 1'b0;
   logic                     reset_i;
   logic                     alloc_valid_i;
   logic                     alloc_ready_o;
   logic [PREG_W-1:0]        alloc_prd_i;
   logic [31:0]              alloc_pc_i;
   logic [IDX_W-1:0]         alloc_idx_o;
   logic [NUM_WB-1:0]        wb_valid_i;
   logic [NUM_WB*IDX_W-1:0]  wb_idx_i;
   logic [NUM_WB*DATA_W-1:0] wb_value_i;
   logic                     commit_valid_o;
   logic                     commit_ready_i;
   logic [IDX_W-1:0]         commit_idx_o;
   logic [PREG_W-1:0]        commit_prd_o;
   logic [DATA_W-1:0]        commit_value_o;
   logic [31:0]              commit_pc_o;
   logic                     flush_i;
   logic                     empty_o;
   logic                     full_o;
   logic [IDX_W:0]           count_o;

   reorder_buffer_n #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .NUM_WB(NUM_WB),
      .DATA_W(DATA_W),
      .PREG_W(PREG_W)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .alloc_valid_i (alloc_valid_i),
      .alloc_ready_o (alloc_ready_o),
      .alloc_prd_i   (alloc_prd_i),
      .alloc_pc_i    (alloc_pc_i),
      .alloc_idx_o   (alloc_idx_o),
      .wb_valid_i    (wb_valid_i),
      .wb_idx_i      (wb_idx_i),
      .wb_value_i    (wb_value_i),
      .commit_valid_o(commit_valid_o),
      .commit_ready_i(commit_ready_i),
      .commit_idx_o  (commit_idx_o),
      .commit_prd_o  (commit_prd_o),
      .commit_value_o(commit_value_o),
      .commit_pc_o   (commit_pc_o),
      .flush_i       (flush_i),
      .empty_o       (empty_o),
      .full_o        (full_o),
      .count_o       (count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                idx;
      logic [PREG_W-1:0] prd;
      logic [31:0]       pc;
      bit                done;
      logic [DATA_W-1:0] value;
   } ent_t;

   // Model: live entries in program order, oldest first, plus the next index to hand out.
   ent_t q[$];
   int   m_tail = 0;
   bit   m_live = 1'b0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update on the same edge the DUT samples its inputs.
   always @(posedge clk) begin : model
      bit   cf;
      bit   af;
      ent_t e;
      if (!reset_i || flush_i) begin
         q.delete();
         m_tail = 0;
         if (!reset_i) m_live = 1'b1;
      end else if (m_live) begin
         cf = (q.size() > 0) && q[0].done && commit_ready_i;
         af = alloc_valid_i && (q.size() < DEPTH);
         for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid_i[k]) begin
               for (int j = 0; j < q.size(); j++) begin
                  if (q[j].idx == int'(wb_idx_i[k*IDX_W +: IDX_W]) && !q[j].done) begin
                     q[j].done  = 1'b1;
                     q[j].value = wb_value_i[k*DATA_W +: DATA_W];
                  end
               end
            end
         end
         if (cf) void'(q.pop_front());
         if (af) begin
            e.idx   = m_tail;
            e.prd   = alloc_prd_i;
            e.pc    = alloc_pc_i;
            e.done  = 1'b0;
            e.value = '0;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
         end
      end
   end

   // Compare every output against the model mid-cycle.
   always @(negedge clk) begin : compare
      int n;
      bit hv;
      if (m_live) begin
         n  = q.size();
         hv = (n > 0) && q[0].done;
         chk("count", count_o, n);
         chk("empty", empty_o, n == 0);
         chk("full", full_o, n == DEPTH);
         chk("alloc_ready", alloc_ready_o, n < DEPTH);
         chk("alloc_idx", alloc_idx_o, m_tail);
         chk("commit_valid", commit_valid_o, hv);
         if (hv) begin
            chk("commit_idx", commit_idx_o, q[0].idx);
            chk("commit_prd", commit_prd_o, q[0].prd);
            chk("commit_value", commit_value_o, q[0].value);
            chk("commit_pc", commit_pc_o, q[0].pc);
         end else begin
            chk("commit_idx_zero", commit_idx_o, 0);
            chk("commit_prd_zero", commit_prd_o, 0);
            chk("commit_value_zero", commit_value_o, 0);
            chk("commit_pc_zero", commit_pc_o, 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset_i        = 1'b1;
      alloc_valid_i  = 1'b0;
      alloc_prd_i    = '0;
      alloc_pc_i     = '0;
      wb_valid_i     = '0;
      wb_idx_i       = '0;
      wb_value_i     = '0;
      commit_ready_i = 1'b0;
      flush_i        = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset_i = 1'b0;
      tick();
      reset_i = 1'b1;
   endtask

   task automatic alloc1(input int prd, input int pc);
      alloc_valid_i = 1'b1;
      alloc_prd_i   = PREG_W'(prd);
      alloc_pc_i    = 32'(pc);
      tick();
      alloc_valid_i = 1'b0;
   endtask

   task automatic set_wb(input int ch, input int idx, input int val);
      wb_valid_i[ch]                  = 1'b1;
      wb_idx_i[ch*IDX_W +: IDX_W]     = IDX_W'(idx);
      wb_value_i[ch*DATA_W +: DATA_W] = DATA_W'(val);
   endtask

   task automatic wb(input int ch, input int idx, input int val);
      set_wb(ch, idx, val);
      tick();
      wb_valid_i = '0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_alloc_ready"}, alloc_ready_o, 1);
      chk({tag, "_alloc_idx"}, alloc_idx_o, 0);
      chk({tag, "_commit_valid"}, commit_valid_o, 0);
      chk({tag, "_commit_fields"}, {commit_idx_o, commit_prd_o, commit_value_o, commit_pc_o}, 0);
      chk({tag, "_empty"}, empty_o, 1);
      chk({tag, "_full"}, full_o, 0);
      chk({tag, "_count"}, count_o, 0);
   endtask

   initial begin
      bit found;
      int n;
      idle();
      reset_i = 1'b0;
      tick();
      tick();
      reset_i = 1'b1;
      check_reset_vals("d_reset");

      // Three allocations then out-of-order writeback, in-order commit.
      for (int i = 0; i < 3; i++) begin
         chk("d_alloc_idx", alloc_idx_o, i);
         alloc1(5 + i, 'h100 + 4 * i);
      end
      chk("d_count3", count_o, 3);
      wb(0, 2, 'h22);
      chk("d_no_commit_yet", commit_valid_o, 0);
      wb(0, 0, 'h20);
      chk("d_head0_valid", commit_valid_o, 1);
      chk("d_head0_prd", commit_prd_o, 5);
      commit_ready_i = 1'b1;
      wb(0, 1, 'h21);
      chk("d_commit_idx1", commit_idx_o, 1);
      chk("d_commit_val1", commit_value_o, 'h21);
      tick();
      chk("d_commit_idx2", commit_idx_o, 2);
      chk("d_commit_prd2", commit_prd_o, 7);
      tick();
      chk("d_drained", empty_o, 1);
      commit_ready_i = 1'b0;

      // Fill, reject the 17th, commit one, wrap to index 0.
      do_reset();
      for (int i = 0; i < DEPTH; i++) alloc1(i, 4 * i);
      chk("d_full", full_o, 1);
      chk("d_full_not_ready", alloc_ready_o, 0);
      alloc_valid_i = 1'b1;
      alloc_prd_i   = 5'd30;
      tick();
      chk("d_17th_rejected", count_o, 16);
      wb(0, 0, 'h55);
      commit_ready_i = 1'b1;
      tick();
      commit_ready_i = 1'b0;
      alloc_valid_i  = 1'b0;
      chk("d_ready_after_commit", alloc_ready_o, 1);
      chk("d_wrap_idx", alloc_idx_o, 0);
      chk("d_count15", count_o, 15);
      alloc1(20, 'h500);
      chk("d_refull", count_o, 16);

      // Three channels hit idx 4 at once: channel 0 wins; later write ignored.
      do_reset();
      for (int i = 0; i < 5; i++) alloc1(i, 'h200 + i);
      for (int ch = 0; ch < NUM_WB; ch++) set_wb(ch, 4, 'hA + ch);
      tick();
      wb_valid_i = '0;
      wb(1, 4, 'hD);
      for (int i = 0; i < 4; i++) wb(2, i, 'h40 + i);
      commit_ready_i = 1'b1;
      found = 1'b0;
      for (int t = 0; t < 10 && !found; t++) begin
         if (commit_valid_o && commit_idx_o == 4'd4) begin
            found = 1'b1;
            chk("d_lowest_channel_wins", commit_value_o, 'hA);
         end else begin
            tick();
         end
      end
      chk("d_idx4_reached", found, 1);
      commit_ready_i = 1'b0;

      // Backpressure holds the head stable; commit plus allocate keeps count.
      do_reset();
      alloc1(9, 'h900);
      alloc1(10, 'h904);
      wb(1, 0, 'hBEEF);
      for (int t = 0; t < 5; t++) begin
         chk("d_hold_valid", commit_valid_o, 1);
         chk("d_hold_fields", {commit_idx_o, commit_prd_o, commit_value_o, commit_pc_o},
             {4'd0, 5'd9, 32'hBEEF, 32'h900});
         tick();
      end
      commit_ready_i = 1'b1;
      alloc_valid_i  = 1'b1;
      alloc_prd_i    = 5'd11;
      tick();
      idle();
      chk("d_commit_alloc_count", count_o, 2);

      // Flush with 6 entries, 3 done, while allocate/writeback/commit are asserted.
      do_reset();
      for (int i = 0; i < 6; i++) alloc1(i + 1, 'h300 + i);
      for (int i = 0; i < 3; i++) wb(0, i, 'h60 + i);
      flush_i        = 1'b1;
      alloc_valid_i  = 1'b1;
      commit_ready_i = 1'b1;
      set_wb(0, 3, 'h63);
      tick();
      idle();
      chk("d_flush_count", count_o, 0);
      chk("d_flush_empty", empty_o, 1);
      chk("d_flush_cv", commit_valid_o, 0);
      chk("d_flush_idx", alloc_idx_o, 0);
      wb(0, 2, 'h77);
      alloc1(3, 'h400);
      chk("d_post_flush_count", count_o, 1);
      chk("d_post_flush_cv", commit_valid_o, 0);

      // Reset mid-stream with 10 entries behaves like flush.
      for (int i = 0; i < 9; i++) alloc1(i, 'h600 + i);
      wb(0, 0, 'h1);
      reset_i        = 1'b0;
      alloc_valid_i  = 1'b1;
      flush_i        = 1'b1;
      commit_ready_i = 1'b1;
      set_wb(1, 1, 'h2);
      tick();
      idle();
      check_reset_vals("d_midreset");

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         idle();
         if ($urandom_range(0, 499) == 0) reset_i = 1'b0;
         if ($urandom_range(0, 99) == 0) flush_i = 1'b1;
         alloc_valid_i  = ($urandom_range(0, 9) < 6);
         alloc_prd_i    = PREG_W'($urandom);
         alloc_pc_i     = $urandom;
         commit_ready_i = ($urandom_range(0, 9) < 7);
         for (int ch = 0; ch < NUM_WB; ch++) begin
            if ($urandom_range(0, 1) == 1) begin
               n = q.size();
               if (n > 0 && $urandom_range(0, 3) != 0)
                  set_wb(ch, q[$urandom_range(0, n - 1)].idx, int'($urandom));
               else
                  set_wb(ch, int'($urandom_range(0, DEPTH - 1)), int'($urandom));
            end
         end
         tick();
      end
      idle();
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
